wb_rr_arbiter2: RTL

//  Two-master, one-slave Wishbone classic arbiter for the vscale SoC bus. Shares
//  one slave port (boot ROM / RAM / UART interconnect) between the core's

---
 rtl/wb_rr_arbiter2_if.sv | 26 ++
 rtl/wb_rr_arbiter2.sv | 128 ++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter2_if.sv
// Wishbone classic bus bundle used by wb_rr_arbiter2 for both master-side and slave-side ports.
// Direction names follow the bus master: dat_w travels master->slave, dat_r slave->master.
interface wb_rr_arbiter2_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            cyc;
   logic            stb;
   logic            we;
   logic [DW/8-1:0] sel;
   logic [AW-1:0]   adr;
   logic [DW-1:0]   dat_w;
   logic [DW-1:0]   dat_r;
   logic            ack;
   logic            err;

   modport master (
      output cyc, stb, we, sel, adr, dat_w,
      input  dat_r, ack, err
   );

   modport slave (
      input  cyc, stb, we, sel, adr, dat_w,
      output dat_r, ack, err
   );
endinterface

// File: rtl/wb_rr_arbiter2.sv
// Two-master Wishbone classic round-robin arbiter with a grant held for the whole bus cycle.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that errors out hung slave accesses.
module wb_rr_arbiter2 #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int FIRST_PRIO     = 0
) (
   input  logic                    clock,
   input  logic                    reset_n,
   wb_rr_arbiter2_if.slave         m0_bus,
   wb_rr_arbiter2_if.slave         m1_bus,
   wb_rr_arbiter2_if.master        s_bus,
   output logic [1:0]              state_o
);
   localparam int SW = DW / 8;

   // Handshake: a master owns the slave from the edge it is granted until it drops cyc;
   // stb/ack/err follow Wishbone classic, so ack or err ends one access and cyc ends the cycle.

   if (TIMEOUT_CYCLES < 2 || FIRST_PRIO < 0 || FIRST_PRIO > 1) begin : g_bad_param
      $error("wb_rr_arbiter2: TIMEOUT_CYCLES must be >= 2 and FIRST_PRIO 0 or 1");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   last_q, last_d;
   logic   g0, g1;
   logic   own_stb;
   logic   tmo;

   logic          s_we_d;
   logic [SW-1:0] s_sel_d;
   logic [AW-1:0] s_adr_d;
   logic [DW-1:0] s_dat_d;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (m0_bus.cyc && m1_bus.cyc) state_d = last_q ? GNT0 : GNT1;
            else if (m0_bus.cyc)          state_d = GNT0;
            else if (m1_bus.cyc)          state_d = GNT1;
         end
         GNT0:    if (!m0_bus.cyc) state_d = m1_bus.cyc ? GNT1 : IDLE;
         GNT1:    if (!m1_bus.cyc) state_d = m0_bus.cyc ? GNT0 : IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d == GNT0 && state_q != GNT0) last_d = 1'b0;
      if (state_d == GNT1 && state_q != GNT1) last_d = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         last_q  <= (FIRST_PRIO == 0);
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   assign g0      = (state_q == GNT0);
   assign g1      = (state_q == GNT1);
   assign own_stb = (g0 & m0_bus.stb) | (g1 & m1_bus.stb);
   assign state_o = state_q;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMO_LIM = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] wdog_q, wdog_d;

   assign tmo = (state_q != IDLE) && (wdog_q == TMO_LIM);

   always_comb begin
      wdog_d = wdog_q;
      if ((state_d != state_q) || s_bus.ack || s_bus.err || tmo) wdog_d = '0;
      else if (own_stb)                                          wdog_d = wdog_q + CW'(1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) wdog_q <= '0;
      else          wdog_q <= wdog_d;
   end
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      s_we_d  = 1'b0;
      s_sel_d = '0;
      s_adr_d = '0;
      s_dat_d = '0;
      if (g0) begin
         s_we_d  = m0_bus.we;
         s_sel_d = m0_bus.sel;
         s_adr_d = m0_bus.adr;
         s_dat_d = m0_bus.dat_w;
      end else if (g1) begin
         s_we_d  = m1_bus.we;
         s_sel_d = m1_bus.sel;
         s_adr_d = m1_bus.adr;
         s_dat_d = m1_bus.dat_w;
      end
   end

   // Slave drive is purely combinational on the grant, so a reset drops it without a clock.
   assign s_bus.cyc   = (g0 & m0_bus.cyc) | (g1 & m1_bus.cyc);
   assign s_bus.stb   = own_stb & ~tmo;
   assign s_bus.we    = s_we_d;
   assign s_bus.sel   = s_sel_d;
   assign s_bus.adr   = s_adr_d;
   assign s_bus.dat_w = s_dat_d;

   assign m0_bus.ack   = g0 & s_bus.ack;
   assign m0_bus.err   = g0 & (s_bus.err | tmo);
   assign m0_bus.dat_r = g0 ? s_bus.dat_r : '0;
   assign m1_bus.ack   = g1 & s_bus.ack;
   assign m1_bus.err   = g1 & (s_bus.err | tmo);
   assign m1_bus.dat_r = g1 ? s_bus.dat_r : '0;
endmodule
